// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - default constants and counter-width helper for the multi-channel debouncer
package debounce_pkg;

    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_SAMPLES      = 8;
    localparam int DEF_TICK_DIV     = 5;
    localparam int DEF_REPEAT_DELAY = 64;
    localparam int DEF_REPEAT_RATE  = 16;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int tick_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce lane: synchroniser, history, hysteresis, pulses; optional DEBOUNCE_AUTOREPEAT_EN
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SAMPLES = DEF_SAMPLES
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_tick,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    logic               r_sync1;
    logic               r_sync2;
    logic [SAMPLES-1:0] r_hist;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic               w_all_one;
    logic               w_all_zero;

    assign w_all_one  = &r_hist;
    assign w_all_zero = ~|r_hist;

    // Level and pulses are decided from the same history, so a pulse lines up with the level change.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_hist    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_hist <= {r_hist[SAMPLES-2:0], r_sync2};
            end
            if (w_all_one) begin
                r_level <= 1'b1;
            end else if (w_all_zero) begin
                r_level <= 1'b0;
            end
            r_press   <= w_all_one & ~r_level;
            r_release <= w_all_zero & r_level;
        end
    end

    assign o_level   = r_level;
    assign o_release = r_release;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = tick_cnt_width(REP_MAX);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_armed;
    logic          r_rep_fire;
    logic [RW-1:0] w_rep_last;

    assign w_rep_last = r_rep_armed ? RATE_LAST : DELAY_LAST;

    // Counts ticks while held; the first interval is the delay, later ones the rate.
    always_ff @(posedge clk) begin
        if (!resetN || !r_level) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
            r_rep_fire  <= 1'b0;
        end else begin
            r_rep_fire <= 1'b0;
            if (i_tick) begin
                if (r_rep_cnt == w_rep_last) begin
                    r_rep_cnt   <= '0;
                    r_rep_armed <= 1'b1;
                    r_rep_fire  <= ~w_all_zero;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end
        end
    end

    assign o_press = r_press | r_rep_fire;
`else
    assign o_press = r_press;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel button debouncer with shared sample tick; optional DEBOUNCE_AUTOREPEAT_EN
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SAMPLES  = DEF_SAMPLES,
    parameter int TICK_DIV = DEF_TICK_DIV
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
`endif
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [CHANNELS-1:0] buttonIn,
    output logic [CHANNELS-1:0] buttonOut,
    output logic [CHANNELS-1:0] pressPulse,
    output logic [CHANNELS-1:0] releasePulse,
    output logic                sampleTick
);

    localparam int CW = tick_cnt_width(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_tick_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_tick;

    assign w_cnt_next = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;

    // The strobe is registered from the next count so it is high exactly while the count sits at its last value.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick_cnt <= w_cnt_next;
            r_tick     <= (w_cnt_next == TICK_LAST);
        end
    end

    assign sampleTick = r_tick;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .SAMPLES      (SAMPLES)
`ifdef DEBOUNCE_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
`endif
        ) u_ch (
            .clk       (clk),
            .resetN    (resetN),
            .i_tick    (r_tick),
            .i_button  (buttonIn[g]),
            .o_level   (buttonOut[g]),
            .o_press   (pressPulse[g]),
            .o_release (releasePulse[g])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - self-checking bench for debouncer_multi
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       resetN;
    logic [3:0] buttonIn;
    logic [3:0] buttonOut;
    logic [3:0] pressPulse;
    logic [3:0] releasePulse;
    logic       sampleTick;

    logic [0:0] buttonIn2;
    logic [0:0] buttonOut2;
    logic [0:0] pressPulse2;
    logic [0:0] releasePulse2;
    logic       sampleTick2;

    int checks   = 0;
    int failures = 0;

    int pc[4], rc[4], first_p[4], first_r[4];
    int cyc, abs_cyc, tickc, tick2c, last_tick, tick_err, overlap_err, ticks_at_press1;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] exp_out;
        logic [3:0] exp_press;
        logic [3:0] exp_rel;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    debouncer_multi #(.CHANNELS(4), .SAMPLES(8), .TICK_DIV(5)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .buttonIn     (buttonIn),
        .buttonOut    (buttonOut),
        .pressPulse   (pressPulse),
        .releasePulse (releasePulse),
        .sampleTick   (sampleTick)
    );

    debouncer_multi #(.CHANNELS(1), .SAMPLES(2), .TICK_DIV(1)) dut_fast (
        .clk          (clk),
        .resetN       (resetN),
        .buttonIn     (buttonIn2),
        .buttonOut    (buttonOut2),
        .pressPulse   (pressPulse2),
        .releasePulse (releasePulse2),
        .sampleTick   (sampleTick2)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic clear_counts();
        cyc = 0;
        tickc = 0;
        tick2c = 0;
        ticks_at_press1 = -1;
        for (int c = 0; c < 4; c++) begin
            pc[c] = 0; rc[c] = 0; first_p[c] = -1; first_r[c] = -1;
        end
    endtask

    // Advance to the next falling edge and accumulate what the DUT shows there.
    task automatic step();
        @(negedge clk);
        cyc++;
        abs_cyc++;
        if (sampleTick) begin
            tickc++;
            if (last_tick >= 0 && abs_cyc - last_tick != 5) tick_err++;
            last_tick = abs_cyc;
        end
        if (sampleTick2) tick2c++;
        if ((pressPulse & releasePulse) != 4'b0) overlap_err++;
        for (int c = 0; c < 4; c++) begin
            if (pressPulse[c]) begin
                if (pc[c] == 0) first_p[c] = cyc;
                if (c == 1 && pc[c] == 0) ticks_at_press1 = tickc;
                pc[c]++;
            end
            if (releasePulse[c]) begin
                if (rc[c] == 0) first_r[c] = cyc;
                rc[c]++;
            end
        end
    endtask

    function automatic logic [31:0] pack_cnt(input int a[4]);
        logic [31:0] r;
        for (int c = 0; c < 4; c++) r[c*8 +: 8] = 8'(a[c]);
        return r;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int c = 0; c < 4; c++) r[c*8 +: 8] = {7'b0, m[c]};
        return r;
    endfunction

    initial begin
        vecs[0] = '{btn: 4'b0000, exp_out: 4'b0000, exp_press: 4'b0000, exp_rel: 4'b1111};
        vecs[1] = '{btn: 4'b0001, exp_out: 4'b0001, exp_press: 4'b0001, exp_rel: 4'b0000};
        vecs[2] = '{btn: 4'b0011, exp_out: 4'b0011, exp_press: 4'b0010, exp_rel: 4'b0000};
        vecs[3] = '{btn: 4'b1010, exp_out: 4'b1010, exp_press: 4'b1000, exp_rel: 4'b0001};
        vecs[4] = '{btn: 4'b0101, exp_out: 4'b0101, exp_press: 4'b0101, exp_rel: 4'b1010};
        vecs[5] = '{btn: 4'b0000, exp_out: 4'b0000, exp_press: 4'b0000, exp_rel: 4'b0101};

        abs_cyc = 0; last_tick = -1; tick_err = 0; overlap_err = 0;
        resetN = 1'b0;
        buttonIn = 4'hF;
        buttonIn2 = 1'b0;
        clear_counts();

        // Reset held with all buttons pressed.
        repeat (10) step();
        chk("rst_outputs", 32'({buttonOut, pressPulse, releasePulse, sampleTick}), 32'h0);
        chk("rst_fast_outputs", 32'({buttonOut2, pressPulse2, releasePulse2, sampleTick2}), 32'h0);
        resetN = 1'b1;
        clear_counts();
        step();
        chk("rst_no_first_pulse", 32'({pressPulse, releasePulse}), 32'h0);
        repeat (59) step();
        chk("rst_press_once", pack_cnt(pc), expand(4'hF));
        chk("rst_press_by_43", 32'(first_p[0] > 0 && first_p[0] <= 43 && first_p[3] == first_p[0]), 32'h1);
        chk("rst_out_held", 32'(buttonOut), 32'hF);

        // Tick period and width, plus the TICK_DIV=1 instance.
        tick_err = 0; last_tick = -1;
        clear_counts();
        repeat (100) step();
        chk("tick_count", 32'(tickc), 32'd20);
        chk("tick_period", 32'(tick_err), 32'd0);
        chk("tick_div1_always", 32'(tick2c), 32'd100);
        buttonIn2 = 1'b1;
        repeat (10) step();
        chk("fast_press", 32'(buttonOut2), 32'h1);

        // Table of stable levels, each held long enough to settle.
        foreach (vecs[i]) begin
            buttonIn = vecs[i].btn;
            clear_counts();
            repeat (50) step();
            chk($sformatf("vec%0d_out", i), 32'(buttonOut), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_press", i), pack_cnt(pc), expand(vecs[i].exp_press));
            chk($sformatf("vec%0d_release", i), pack_cnt(rc), expand(vecs[i].exp_rel));
        end

        // Bounce on ch0: 3-clk toggles never give 8 equal samples.
        clear_counts();
        for (int t = 0; t < 40; t++) begin
            buttonIn[0] = ~buttonIn[0];
            repeat (3) step();
        end
        chk("bounce_no_pulse", 32'(pc[0] + rc[0]), 32'd0);
        buttonIn[0] = 1'b1;
        clear_counts();
        repeat (50) step();
        chk("bounce_press_once", 32'(pc[0]), 32'd1);
        chk("bounce_press_by_43", 32'(first_p[0] > 0 && first_p[0] <= 43), 32'h1);

        // Release hysteresis on ch1.
        buttonIn[1] = 1'b1;
        repeat (50) step();
        chk("hyst_pressed", 32'(buttonOut[1]), 32'h1);
        clear_counts();
        buttonIn[1] = 1'b0;
        repeat (5) step();
        buttonIn[1] = 1'b1;
        repeat (50) step();
        chk("hyst_glitch_no_release", 32'(rc[1]), 32'd0);
        chk("hyst_glitch_held", 32'(buttonOut[1]), 32'h1);
        buttonIn[1] = 1'b0;
        clear_counts();
        repeat (50) step();
        chk("hyst_release_once", 32'(rc[1]), 32'd1);
        chk("hyst_release_by_43", 32'(first_r[1] > 0 && first_r[1] <= 43), 32'h1);

        // Simultaneous press on ch2 and release on ch3.
        buttonIn[3] = 1'b1;
        repeat (50) step();
        buttonIn[2] = 1'b1;
        buttonIn[3] = 1'b0;
        clear_counts();
        repeat (50) step();
        chk("simul_counts", 32'({8'(pc[2]), 8'(rc[3])}), 32'h0101);
        chk("simul_same_cycle", 32'(first_p[2] == first_r[3] && first_p[2] > 0), 32'h1);
        chk("simul_out", 32'(buttonOut), 32'h5);
        chk("simul_others_quiet", 32'({8'(pc[0]), 8'(pc[1]), 8'(rc[0]), 8'(rc[1])}), 32'h0);

        // Reset at the fifth tick of a ch1 press discards the partial history.
        buttonIn[1] = 1'b1;
        clear_counts();
        for (int k = 0; k < 100 && tickc < 5; k++) step();
        chk("mid_reach_tick5", 32'(tickc), 32'd5);
        chk("mid_no_early_press", 32'(pc[1]), 32'd0);
        resetN = 1'b0;
        step();
        chk("mid_rst_outputs", 32'({buttonOut, pressPulse, releasePulse}), 32'h0);
        resetN = 1'b1;
        clear_counts();
        repeat (60) step();
        chk("mid_press_once", 32'(pc[1]), 32'd1);
        chk("mid_ticks_before_press", 32'(ticks_at_press1), 32'd8);
        chk("mid_latency", 32'(first_p[1] >= 39 && first_p[1] <= 43), 32'h1);
        chk("mid_held_chans", 32'({8'(pc[0]), 8'(pc[2]), 8'(pc[3])}), 32'h010100);

        chk("no_press_release_overlap", 32'(overlap_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
